// File: rtl/lab2_serial_sub16_if.sv
// Handshake and result bundle for the serial multi-nibble subtractor.
interface lab2_serial_sub16_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         bin;
  logic         ready;
  logic         done;
  logic [W-1:0] d_out;
  logic         bout;
  logic         zero;
  logic         ovf;

  modport master (
    output start, a_in, b_in, bin,
    input  ready, done, d_out, bout, zero, ovf
  );

  modport slave (
    input  start, a_in, b_in, bin,
    output ready, done, d_out, bout, zero, ovf
  );
endinterface

// File: rtl/lab2_serial_sub16.sv
// Serial subtractor: latches a W-bit operand pair and resolves one 4-bit
// borrow-lookahead nibble per clock, LS nibble first, with the inter-nibble
// borrow held in a register.
//
// state | meaning
// IDLE  | ready=1, waiting for start
// RUN   | one nibble resolved per edge
// DONE  | one-cycle done pulse, results stable
module lab2_serial_sub16 #(
  parameter int NIBBLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  lab2_serial_sub16_if.slave bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, b_q, d_q, d_next;
  logic          brw_q;
  logic [IW-1:0] idx_q;
  logic          bout_q, zero_q, ovf_q;
  logic [3:0]    a_nib, b_nib, g, p, diff;
  logic [4:0]    c;
  logic          accept, last;

  assign accept = bus.start && (state_q == IDLE);
  assign last   = (idx_q == LAST);

  // Borrow-lookahead slice on the current nibble, plus the merged next d_out.
  always_comb begin
    a_nib = a_q[{idx_q, 2'b00} +: 4];
    b_nib = b_q[{idx_q, 2'b00} +: 4];
    g     = ~a_nib & b_nib;
    p     = ~(a_nib ^ b_nib);
    c     = '0;
    c[0]  = brw_q;
    for (int i = 0; i < 4; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    diff   = ~p ^ c[3:0];
    d_next = d_q;
    d_next[{idx_q, 2'b00} +: 4] = diff;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand latch, borrow/index stepping and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      d_q    <= '0;
      brw_q  <= 1'b0;
      idx_q  <= '0;
      bout_q <= 1'b0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      a_q   <= bus.a_in;
      b_q   <= bus.b_in;
      brw_q <= bus.bin;
      idx_q <= '0;
    end else if (state_q == RUN) begin
      d_q   <= d_next;
      brw_q <= c[4];
      if (last) begin
        // Index parks at the last nibble; the next accept resets it.
        bout_q <= c[4];
        ovf_q  <= c[3] ^ c[4];
        zero_q <= (d_next == '0);
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  assign bus.ready = (state_q == IDLE);
  assign bus.done  = (state_q == DONE);
  assign bus.d_out = d_q;
  assign bus.bout  = bout_q;
  assign bus.zero  = zero_q;
  assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_lab2_serial_sub16.sv
// Scoreboard bench for lab2_serial_sub16: stimulus pushes hand-computed
// results, a monitor pops and compares on every done pulse.
module tb_lab2_serial_sub16;
  localparam int N = 4;
  localparam int W = 4 * N;

  typedef struct {
    logic [W-1:0] d;
    logic         bout;
    logic         zero;
    logic         ovf;
    int           acc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cnt;
  int   pass_cnt;
  int   total_cnt;
  exp_t sb[$];

  lab2_serial_sub16_if #(.NIBBLES(N)) bus ();

  lab2_serial_sub16 #(.NIBBLES(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: at a negedge, cnt is the number of rising edges so far.
  always @(posedge clk) cnt <= cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: every done cycle must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("d_out", 32'(bus.d_out), 32'(e.d));
        chk("bout",  32'(bus.bout),  32'(e.bout));
        chk("zero",  32'(bus.zero),  32'(e.zero));
        chk("ovf",   32'(bus.ovf),   32'(e.ovf));
        chk("done_latency", 32'(cnt - e.acc), 32'(N));
        chk("ready_in_done", 32'(bus.ready), 32'd0);
      end
    end
  end

  task automatic wait_ready(output int ok);
    int t;
    t  = 0;
    ok = 1;
    while (bus.ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (bus.ready !== 1'b1) begin
      chk("ready_timeout", 32'd0, 32'd1);
      ok = 0;
    end
  endtask

  // Issue one op from a negedge; returns the accepting edge number.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                       input logic [W-1:0] d, input logic bo, input logic z, input logic ov,
                       output int acc);
    int   ok;
    exp_t e;
    wait_ready(ok);
    bus.start = 1'b1;
    bus.a_in  = a;
    bus.b_in  = b;
    bus.bin   = bi;
    acc    = cnt + 1;
    e.d    = d;
    e.bout = bo;
    e.zero = z;
    e.ovf  = ov;
    e.acc  = acc;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a_in  = ~a;
    bus.b_in  = a;
    bus.bin   = ~bi;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int acc, acc2, ok;
    cnt       = 0;
    pass_cnt  = 0;
    total_cnt = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    bus.bin   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_done",  32'(bus.done),  32'd0);
    chk("rst_d_out", 32'(bus.d_out), 32'd0);
    chk("rst_flags", {29'd0, bus.bout, bus.zero, bus.ovf}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic vector; borrow ripple through all nibbles; signed overflow; zero.
    issue(16'h1234, 16'h0FF5, 1'b0, 16'h023F, 1'b0, 1'b0, 1'b0, acc);
    drain();
    issue(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, acc);
    drain();
    issue(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1, acc);
    drain();
    issue(16'h5A5A, 16'h5A59, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, acc);
    drain();
    issue(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, acc);
    drain();

    // Reset mid-RUN: no result may survive and no done may follow.
    wait_ready(ok);
    bus.start = 1'b1;
    bus.a_in  = 16'h1234;
    bus.b_in  = 16'h0FF5;
    bus.bin   = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrun_ready", 32'(bus.ready), 32'd1);
    chk("midrun_done",  32'(bus.done),  32'd0);
    chk("midrun_d_out", 32'(bus.d_out), 32'd0);
    chk("midrun_flags", {29'd0, bus.bout, bus.zero, bus.ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("midrun_no_done_ready", 32'(bus.ready), 32'd1);

    // start held high with operands scrambled every cycle after acceptance.
    wait_ready(ok);
    bus.start = 1'b1;
    bus.a_in  = 16'h8000;
    bus.b_in  = 16'h0001;
    bus.bin   = 1'b0;
    acc = cnt + 1;
    sb.push_back('{d: 16'h7FFF, bout: 1'b0, zero: 1'b0, ovf: 1'b1, acc: acc});
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk("hold_ready_low", 32'(bus.ready), 32'd0);
      bus.a_in = 16'(16'h1111 * (k + 3));
      bus.b_in = 16'(16'h2222 * (k + 1));
      bus.bin  = k[0];
      @(negedge clk);
    end
    chk("hold_ready_back", 32'(bus.ready), 32'd1);
    bus.a_in = 16'h1234;
    bus.b_in = 16'h0FF5;
    bus.bin  = 1'b0;
    acc2 = cnt + 1;
    chk("hold_second_accept", 32'(acc2 - acc), 32'd6);
    sb.push_back('{d: 16'h023F, bout: 1'b0, zero: 1'b0, ovf: 1'b0, acc: acc2});
    @(negedge clk);
    bus.start = 1'b0;
    bus.a_in  = 16'hFFFF;
    bus.b_in  = 16'h0000;
    bus.bin   = 1'b1;
    drain();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
